bus_interconnect: RTL and testbench

//  Parametrised CPU-to-peripheral bus decoder/response mux with wait-state support.

---
 rtl/soc_bus_pkg.sv | 15 +
 rtl/bus_region_decode.sv | 31 +++
 rtl/bus_interconnect.sv | 124 ++++++++++++
 tb/tb_bus_interconnect.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus definitions: FSM states and sticky error codes.
// Also used by the lsio block's error reporting.
package soc_bus_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } bus_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERLAP  = 2'b11;

endpackage

// File: rtl/bus_region_decode.sv
// Address region decoder: top SEL_BITS of addr -> slave hit/index.
// On duplicate ids the lowest slave index wins.
module bus_region_decode #(
    parameter int ADDR_W   = 32,
    parameter int NSLAVES  = 4,
    parameter int SEL_BITS = 3,
    parameter logic [NSLAVES*SEL_BITS-1:0] SLAVE_IDS = {3'd4, 3'd2, 3'd1, 3'd0},
    localparam int IDX_W   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [SEL_BITS-1:0] region;

    assign region = addr[ADDR_W-1 -: SEL_BITS];

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (region == SLAVE_IDS[i*SEL_BITS +: SEL_BITS]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// CPU-to-peripheral bus decoder and response mux with wait states,
// unmapped-address and slave-timeout error reporting.
module bus_interconnect
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NSLAVES  = 4,
    parameter int SEL_BITS = 3,
    parameter logic [NSLAVES*SEL_BITS-1:0] SLAVE_IDS = {3'd4, 3'd2, 3'd1, 3'd0},
    parameter int TIMEOUT  = 15
) (
    input  logic                      clk_i,
    input  logic                      rstn,
    input  logic                      enable_i,
    input  logic [DATA_W/8-1:0]       wstrb_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         wvalue_i,
    output logic [DATA_W-1:0]         rvalue_o,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [ADDR_W-1:0]         err_addr_o,
    output logic [NSLAVES-1:0]        s_sel_o,
    output logic [DATA_W/8-1:0]       s_wstrb_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wvalue_o,
    input  logic [NSLAVES*DATA_W-1:0] s_rvalue_i,
    input  logic [NSLAVES-1:0]        s_ready_i
);

    localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    bus_state_e        state, state_nx;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              unm_q;
    logic [1:0]        code_q;
    logic [ADDR_W-1:0] eaddr_q;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              in_wait, s_rdy, tmo, done, free;
    logic              req_ok, accept, unmapped, overlap;

    bus_region_decode #(
        .ADDR_W   (ADDR_W),
        .NSLAVES  (NSLAVES),
        .SEL_BITS (SEL_BITS),
        .SLAVE_IDS(SLAVE_IDS)
    ) u_decode (
        .addr(addr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign s_wstrb_o  = wstrb_i;
    assign s_addr_o   = addr_i;
    assign s_wvalue_o = wvalue_i;

    assign in_wait  = (state == WAIT);
    assign s_rdy    = s_ready_i[idx_q];
    assign tmo      = in_wait && !s_rdy && (cnt_q == 8'(TIMEOUT));
    assign done     = in_wait && (s_rdy || tmo);
    assign busy_o   = in_wait && !done;
    // The completion cycle is free: a new request may be accepted there.
    assign free     = !in_wait || done;
    assign req_ok   = rstn && enable_i && free;
    assign accept   = req_ok && dec_hit;
    assign unmapped = req_ok && !dec_hit;
    assign overlap  = rstn && enable_i && busy_o;

    assign ready_o  = unm_q || done;
    assign err_o    = unm_q || tmo;
    assign rvalue_o = (in_wait && s_rdy) ?
                      s_rvalue_i[int'(idx_q)*DATA_W +: DATA_W] : '0;
    assign s_sel_o  = accept ? (NSLAVES'(1) << dec_idx) : '0;

    // Timeout code is shown in the same cycle as its error pulse.
    assign err_code_o = tmo ? ERR_TIMEOUT : code_q;
    assign err_addr_o = tmo ? addr_q : eaddr_q;

    always_comb begin
        state_nx = state;
        if (done) state_nx = IDLE;
        if (accept) state_nx = WAIT;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            state   <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            unm_q   <= 1'b0;
            code_q  <= ERR_NONE;
            eaddr_q <= '0;
        end else begin
            state <= state_nx;
            unm_q <= unmapped;
            if (accept) begin
                idx_q  <= dec_idx;
                cnt_q  <= '0;
                addr_q <= addr_i;
            end else if (busy_o) begin
                cnt_q <= cnt_q + 8'd1;
            end
            // A new request's error is newer than a timeout ending now.
            if (unmapped) begin
                code_q  <= ERR_UNMAPPED;
                eaddr_q <= addr_i;
            end else if (overlap) begin
                code_q  <= ERR_OVERLAP;
                eaddr_q <= addr_i;
            end else if (tmo) begin
                code_q  <= ERR_TIMEOUT;
                eaddr_q <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Testbench for bus_interconnect: directed cases followed by random
// transactions checked against a transaction-level model.
module tb_bus_interconnect;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 15;

    logic             clk_i = 1'b0;
    logic             rstn = 1'b0;
    logic             enable_i = 1'b0;
    logic [DW/8-1:0]  wstrb_i = '0;
    logic [AW-1:0]    addr_i = '0;
    logic [DW-1:0]    wvalue_i = '0;
    logic [DW-1:0]    rvalue_o;
    logic             ready_o;
    logic             busy_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic [AW-1:0]    err_addr_o;
    logic [NS-1:0]    s_sel_o;
    logic [DW/8-1:0]  s_wstrb_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_wvalue_o;
    logic [NS*DW-1:0] s_rvalue_i = '0;
    logic [NS-1:0]    s_ready_i = '0;

    int tests = 0;
    int failed = 0;

    logic [1:0]  exp_code = 2'b00;
    logic [31:0] exp_eaddr = '0;
    logic [31:0] rdata[NS];
    int          ids[NS] = '{0, 1, 2, 4};

    bus_interconnect dut (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .enable_i  (enable_i),
        .wstrb_i   (wstrb_i),
        .addr_i    (addr_i),
        .wvalue_i  (wvalue_i),
        .rvalue_o  (rvalue_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .err_code_o(err_code_o),
        .err_addr_o(err_addr_o),
        .s_sel_o   (s_sel_o),
        .s_wstrb_o (s_wstrb_o),
        .s_addr_o  (s_addr_o),
        .s_wvalue_o(s_wvalue_o),
        .s_rvalue_i(s_rvalue_i),
        .s_ready_i (s_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if (ids[i] == int'(a[31:29])) return i;
        return -1;
    endfunction

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic load_data();
        for (int i = 0; i < NS; i++) begin
            rdata[i] = $urandom;
            s_rvalue_i[i*DW +: DW] = rdata[i];
        end
    endtask

    // One request from an idle bus; lat = cycles the slave holds ready low.
    task automatic run_txn(input logic [31:0] a, input logic [3:0] ws,
                           input int lat);
        int r;
        int resp;
        r = region(a);
        step();
        enable_i = 1'b1;
        addr_i = a;
        wstrb_i = ws;
        wvalue_i = $urandom;
        s_ready_i = '0;
        #1;
        chk("s_sel", 64'(s_sel_o), (r < 0) ? 64'd0 : 64'(1 << r));
        chk("s_bcast", {s_addr_o, s_wvalue_o}, {a, wvalue_i});
        if (r < 0) begin
            step();
            enable_i = 1'b0;
            #1;
            exp_code = 2'b01;
            exp_eaddr = a;
            chk("unm_ready", 64'(ready_o), 64'd1);
            chk("unm_err", 64'(err_o), 64'd1);
            chk("unm_rvalue", 64'(rvalue_o), 64'd0);
            chk("unm_code", 64'(err_code_o), 64'(exp_code));
            chk("unm_eaddr", 64'(err_addr_o), 64'(exp_eaddr));
        end else begin
            resp = ((lat > TO) ? TO : lat) + 1;
            for (int k = 1; k <= resp; k++) begin
                step();
                enable_i = 1'b0;
                s_ready_i = (k == lat + 1) ? NS'(1 << r) : '0;
                #1;
                if (k < resp) begin
                    chk("wait_busy", 64'(busy_o), 64'd1);
                    chk("wait_ready", 64'(ready_o), 64'd0);
                end else begin
                    chk("resp_ready", 64'(ready_o), 64'd1);
                    chk("resp_busy", 64'(busy_o), 64'd0);
                    chk("resp_err", 64'(err_o), 64'(lat > TO));
                    if (lat > TO) begin
                        chk("tmo_rvalue", 64'(rvalue_o), 64'd0);
                        exp_code = 2'b10;
                        exp_eaddr = a;
                    end else if (ws == 4'd0) begin
                        chk("rd_data", 64'(rvalue_o), 64'(rdata[r]));
                    end
                end
            end
        end
        // After a timeout the slave answers late; that must be ignored.
        step();
        enable_i = 1'b0;
        s_ready_i = (r >= 0 && lat > TO) ? NS'(1 << r) : '0;
        #1;
        chk("idle_ready", 64'(ready_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_err", 64'(err_o), 64'd0);
        chk("sticky_code", 64'(err_code_o), 64'(exp_code));
        chk("sticky_addr", 64'(err_addr_o), 64'(exp_eaddr));
        s_ready_i = '0;
    endtask

    initial begin
        int lat;
        logic [31:0] a;

        rstn = 1'b0;
        repeat (2) step();
        #1;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_code", 64'(err_code_o), 64'd0);
        chk("rst_eaddr", 64'(err_addr_o), 64'd0);
        chk("rst_rvalue", 64'(rvalue_o), 64'd0);
        rstn = 1'b1;

        // Zero-wait read of slave 1.
        load_data();
        rdata[1] = 32'hDEAD_BEEF;
        s_rvalue_i[1*DW +: DW] = rdata[1];
        run_txn(32'h2000_0010, 4'd0, 0);

        // Three wait states on slave 3.
        load_data();
        run_txn(32'h8000_0000, 4'd0, 3);

        // Unmapped region.
        load_data();
        run_txn(32'h6000_0000, 4'd0, 0);

        // Slave 0 never ready.
        load_data();
        run_txn(32'h0000_0100, 4'd0, 100);

        // Back-to-back: slave 0 requested in slave 2's completion cycle.
        load_data();
        step();
        enable_i = 1'b1;
        addr_i = 32'h4000_0000;
        wstrb_i = 4'd0;
        #1;
        chk("b2b_sel2", 64'(s_sel_o), 64'b0100);
        step();
        addr_i = 32'h0000_0040;
        s_ready_i = 4'b0100;
        #1;
        chk("b2b_ready1", 64'(ready_o), 64'd1);
        chk("b2b_data1", 64'(rvalue_o), 64'(rdata[2]));
        chk("b2b_sel0", 64'(s_sel_o), 64'b0001);
        step();
        enable_i = 1'b0;
        s_ready_i = 4'b0001;
        #1;
        chk("b2b_ready2", 64'(ready_o), 64'd1);
        chk("b2b_data2", 64'(rvalue_o), 64'(rdata[0]));
        chk("b2b_err2", 64'(err_o), 64'd0);
        step();
        s_ready_i = '0;
        #1;
        chk("b2b_idle", 64'(ready_o), 64'd0);

        // Request while busy is dropped and only recorded.
        load_data();
        step();
        enable_i = 1'b1;
        addr_i = 32'h2000_0000;
        #1;
        chk("ovl_sel1", 64'(s_sel_o), 64'b0010);
        step();
        addr_i = 32'h8000_0004;
        #1;
        chk("ovl_busy", 64'(busy_o), 64'd1);
        chk("ovl_nosel", 64'(s_sel_o), 64'd0);
        chk("ovl_noerr", 64'(err_o), 64'd0);
        step();
        enable_i = 1'b0;
        #1;
        exp_code = 2'b11;
        exp_eaddr = 32'h8000_0004;
        chk("ovl_code", 64'(err_code_o), 64'(exp_code));
        chk("ovl_eaddr", 64'(err_addr_o), 64'(exp_eaddr));
        chk("ovl_err", 64'(err_o), 64'd0);
        step();
        s_ready_i = 4'b0010;
        #1;
        chk("ovl_resp", 64'(ready_o), 64'd1);
        chk("ovl_data", 64'(rvalue_o), 64'(rdata[1]));
        step();
        s_ready_i = '0;
        #1;
        chk("ovl_idle", 64'(ready_o), 64'd0);

        // Reset in the middle of a wait.
        step();
        enable_i = 1'b1;
        addr_i = 32'h2000_0020;
        step();
        enable_i = 1'b0;
        step();
        #1;
        chk("rstw_busy", 64'(busy_o), 64'd1);
        step();
        rstn = 1'b0;
        step();
        #1;
        exp_code = 2'b00;
        exp_eaddr = '0;
        chk("rstw_busy0", 64'(busy_o), 64'd0);
        chk("rstw_ready0", 64'(ready_o), 64'd0);
        chk("rstw_code0", 64'(err_code_o), 64'd0);
        rstn = 1'b1;
        load_data();
        run_txn(32'h4000_0008, 4'd0, 1);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            lat = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
            load_data();
            run_txn(a, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom), lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
